// File: rtl/vx_cta_dispatcher_pkg.sv
// vx_cta_dispatcher_pkg: shared sizes, FSM state, grid coordinate type and thread-mask helper
package vx_cta_dispatcher_pkg;
  localparam int NUM_WARPS = 4;
  localparam int NUM_THREADS = 4;
  localparam int PERF_CTR_BITS = 44;
  localparam int INFL_BITS = 4;
  localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int CTA_TW = $clog2(NUM_THREADS + 1);
  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} cta_state_e;
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } cta_coord_t;
  // Lane mask for a CTA of bt threads; 0 or oversize requests fill the whole warp.
  function automatic logic [NUM_THREADS-1:0] thread_mask(input logic [CTA_TW-1:0] bt);
    logic [CTA_TW-1:0] n;
    logic [NUM_THREADS-1:0] m;
    n = (bt == '0 || bt > CTA_TW'(NUM_THREADS)) ? CTA_TW'(NUM_THREADS) : bt;
    for (int i = 0; i < NUM_THREADS; i++) m[i] = i < int'(n);
    return m;
  endfunction
endpackage

// File: rtl/vx_cta_dispatcher_prio_enc.sv
// vx_cta_dispatcher_prio_enc: LSB-first priority encoder used to pick the lowest free warp
module vx_cta_dispatcher_prio_enc #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] data_i,
  output logic [W-1:0] index_o,
  output logic         valid_o
);
  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    index_o = '0;
    for (int i = N - 1; i >= 0; i--) if (data_i[i]) index_o = W'(i);
  end
  assign valid_o = |data_i;
endmodule

// File: rtl/vx_cta_dispatcher.sv
// vx_cta_dispatcher: walks the CTA grid onto free warps and drives the scheduler CSR signal group
module vx_cta_dispatcher
  import vx_cta_dispatcher_pkg::*;
(
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             start_i,
  input  logic [31:0]                      grid_x_i,
  input  logic [31:0]                      grid_y_i,
  input  logic [31:0]                      grid_z_i,
  input  logic [CTA_TW-1:0]                block_threads_i,
  input  logic                             warp_done_i,
  input  logic [NW_WIDTH-1:0]              warp_done_wid_i,
  input  logic                             issue_fire_i,
  input  logic [NW_WIDTH-1:0]              issue_wid_i,
  input  logic                             commit_fire_i,
  input  logic [NW_WIDTH-1:0]              commit_wid_i,
  input  logic                             csr_lock_i,
  input  logic [NW_WIDTH-1:0]              csr_lock_wid_i,
  input  logic [NW_WIDTH-1:0]              alm_empty_wid_i,
  input  logic [NW_WIDTH-1:0]              unlock_wid_i,
  input  logic                             unlock_warp_i,
  output logic [PERF_CTR_BITS-1:0]         cycles_o,
  output logic [NUM_WARPS-1:0]             active_warps_o,
  output logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks_o,
  output logic [NUM_WARPS*32-1:0]          cta_x_o,
  output logic [NUM_WARPS*32-1:0]          cta_y_o,
  output logic [NUM_WARPS*32-1:0]          cta_z_o,
  output logic [NUM_WARPS*32-1:0]          cta_id_o,
  output logic                             alm_empty_o,
  output logic [NUM_WARPS-1:0]             locked_warps_o,
  output logic                             busy_o,
  output logic                             kernel_done_o
);
  cta_state_e               state_q;
  cta_coord_t               grid_q, cursor_q, cursor_d;
  logic [CTA_TW-1:0]        bt_q;
  logic [31:0]              next_id_q;
  logic [NUM_WARPS-1:0]     active_q, locked_q;
  logic [NUM_THREADS-1:0]   masks_q [NUM_WARPS];
  cta_coord_t               coord_q [NUM_WARPS];
  logic [31:0]              id_q [NUM_WARPS];
  logic [INFL_BITS-1:0]     infl_q [NUM_WARPS];
  logic                     kernel_done_q;
  logic [PERF_CTR_BITS-1:0] cycles_q;
  logic [NW_WIDTH-1:0]      free_idx;
  logic                     free_valid, last_x, last_y, last_z, done_ok;
  logic [NUM_WARPS-1:0]     inc_v, dec_v, lock_v, unlock_v, retire_v;

  vx_cta_dispatcher_prio_enc #(.N(NUM_WARPS), .W(NW_WIDTH)) u_free (
    .data_i  (~active_q),
    .index_o (free_idx),
    .valid_o (free_valid)
  );

  assign last_x   = cursor_q.x == grid_q.x - 32'd1;
  assign last_y   = cursor_q.y == grid_q.y - 32'd1;
  assign last_z   = cursor_q.z == grid_q.z - 32'd1;
  assign done_ok  = warp_done_i && active_q[warp_done_wid_i];
  assign inc_v    = issue_fire_i ? NUM_WARPS'(1) << issue_wid_i : '0;
  assign dec_v    = commit_fire_i ? NUM_WARPS'(1) << commit_wid_i : '0;
  assign lock_v   = csr_lock_i ? NUM_WARPS'(1) << csr_lock_wid_i : '0;
  assign unlock_v = unlock_warp_i ? NUM_WARPS'(1) << unlock_wid_i : '0;
  assign retire_v = done_ok ? NUM_WARPS'(1) << warp_done_wid_i : '0;

  // Grid cursor step: x fastest, carrying into y then z.
  always_comb begin
    cursor_d.x = last_x ? '0 : cursor_q.x + 32'd1;
    cursor_d.y = last_x ? (last_y ? '0 : cursor_q.y + 32'd1) : cursor_q.y;
    cursor_d.z = (last_x && last_y) ? cursor_q.z + 32'd1 : cursor_q.z;
  end

  // Kernel FSM with per-warp CTA assignment and retirement.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      grid_q        <= '0;
      cursor_q      <= '0;
      bt_q          <= '0;
      next_id_q     <= '0;
      active_q      <= '0;
      kernel_done_q <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        masks_q[w] <= '0;
        coord_q[w] <= '0;
        id_q[w]    <= '0;
      end
    end else begin
      assert (!warp_done_i || active_q[warp_done_wid_i]);
      kernel_done_q <= 1'b0;
      if (done_ok) begin
        active_q[warp_done_wid_i] <= 1'b0;
        masks_q[warp_done_wid_i]  <= '0;
      end
      case (state_q)
        IDLE: if (start_i) begin
          if (grid_x_i == '0 || grid_y_i == '0 || grid_z_i == '0) kernel_done_q <= 1'b1;
          else begin
            state_q   <= DISPATCH;
            grid_q    <= '{x: grid_x_i, y: grid_y_i, z: grid_z_i};
            bt_q      <= block_threads_i;
            cursor_q  <= '0;
            next_id_q <= '0;
          end
        end
        DISPATCH: if (free_valid) begin
          active_q[free_idx] <= 1'b1;
          masks_q[free_idx]  <= thread_mask(bt_q);
          coord_q[free_idx]  <= cursor_q;
          id_q[free_idx]     <= next_id_q;
          cursor_q           <= cursor_d;
          next_id_q          <= next_id_q + 32'd1;
          if (last_x && last_y && last_z) state_q <= DRAIN;
        end
        DRAIN: if (active_q == '0) begin
          kernel_done_q <= 1'b1;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Per-warp in-flight counters; saturate instead of wrapping.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) for (int w = 0; w < NUM_WARPS; w++) infl_q[w] <= '0;
    else for (int w = 0; w < NUM_WARPS; w++) begin
      if (inc_v[w] && !dec_v[w]) begin
        assert (infl_q[w] != '1);
        if (infl_q[w] != '1) infl_q[w] <= infl_q[w] + 1'b1;
      end
      if (dec_v[w] && !inc_v[w]) begin
        assert (infl_q[w] != '0);
        if (infl_q[w] != '0) infl_q[w] <= infl_q[w] - 1'b1;
      end
    end
  end

  // CSR lock mask: unlock and retirement take precedence over a new lock.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) locked_q <= '0;
    else locked_q <= (locked_q | lock_v) & ~(unlock_v | retire_v);
  end

  // Free-running cycle counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cycles_q <= '0;
    else cycles_q <= cycles_q + 1'b1;
  end

  // Flatten per-warp tables onto the CSR signal group.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      thread_masks_o[w*NUM_THREADS +: NUM_THREADS] = masks_q[w];
      cta_x_o[w*32 +: 32]  = coord_q[w].x;
      cta_y_o[w*32 +: 32]  = coord_q[w].y;
      cta_z_o[w*32 +: 32]  = coord_q[w].z;
      cta_id_o[w*32 +: 32] = id_q[w];
    end
  end

  assign cycles_o       = cycles_q;
  assign active_warps_o = active_q;
  assign locked_warps_o = locked_q;
  assign alm_empty_o    = infl_q[alm_empty_wid_i] == '0;
  assign busy_o         = state_q != IDLE;
  assign kernel_done_o  = kernel_done_q;
endmodule
